// File: rtl/elixirchip_es1_spu_op_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : elixirchip_es1_spu_op_mem_arbiter
//  Purpose  : Shares one SPU operator memory among NUM_PORTS requesters.
//             Independent round-robin arbiters for the write and the read
//             port. Each arbiter issues one grant per enabled cycle. Read data
//             is steered back to its requester through an ID pipeline that is
//             as deep as the memory read latency.
//  Revision : 1.0  initial release
// ============================================================================
module elixirchip_es1_spu_op_mem_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_BITS = 18,
   parameter int ADDR_BITS = 10,
   parameter int RLATENCY  = 2,
   parameter int ID_BITS   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                           reset_n,
   input  logic                           clk,
   input  logic                           cke,

   input  logic [NUM_PORTS*ADDR_BITS-1:0] s_waddr,
   input  logic [NUM_PORTS*DATA_BITS-1:0] s_wdata,
   input  logic [NUM_PORTS-1:0]           s_wvalid,
   output logic [NUM_PORTS-1:0]           s_wready,

   input  logic [NUM_PORTS*ADDR_BITS-1:0] s_raddr,
   input  logic [NUM_PORTS-1:0]           s_rvalid,
   output logic [NUM_PORTS-1:0]           s_rready,

   output logic [DATA_BITS-1:0]           m_rdata,
   output logic [NUM_PORTS-1:0]           m_rvalid,

   output logic [ADDR_BITS-1:0]           mem_waddr,
   output logic [DATA_BITS-1:0]           mem_wdata,
   output logic                           mem_wvalid,
   output logic [ADDR_BITS-1:0]           mem_raddr,
   output logic                           mem_rvalid,
   input  logic [DATA_BITS-1:0]           mem_rdata
);

   // Index of the highest-numbered port; the pointer wraps to 0 after it.
   localparam logic [ID_BITS-1:0] c_LAST_ID = ID_BITS'(NUM_PORTS - 1);

   // ------------------------------------------------------------------------
   // Per-port views of the flat request buses
   // ------------------------------------------------------------------------
   logic [ADDR_BITS-1:0] w_waddr_arr [NUM_PORTS];
   logic [DATA_BITS-1:0] w_wdata_arr [NUM_PORTS];
   logic [ADDR_BITS-1:0] w_raddr_arr [NUM_PORTS];

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign w_waddr_arr[gi] = s_waddr[gi*ADDR_BITS +: ADDR_BITS];
      assign w_wdata_arr[gi] = s_wdata[gi*DATA_BITS +: DATA_BITS];
      assign w_raddr_arr[gi] = s_raddr[gi*ADDR_BITS +: ADDR_BITS];
   end

   // ------------------------------------------------------------------------
   // Round-robin pick: first requesting port at or above the pointer, or
   // failing that the lowest requesting port (wrap-around part of the search).
   // Result is {any_request, port_index}.
   // ------------------------------------------------------------------------
   function automatic logic [ID_BITS:0] rr_pick(
      input logic [NUM_PORTS-1:0] req,
      input logic [ID_BITS-1:0]   ptr
   );
      logic               found_hi;
      logic [ID_BITS-1:0] id_hi;
      logic [ID_BITS-1:0] id_lo;
      found_hi = 1'b0;
      id_hi    = '0;
      id_lo    = '0;
      // Descending scan so the last hit (the lowest index) wins.
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[i]) begin
            id_lo = ID_BITS'(i);
         end
         if (req[i] && (ID_BITS'(i) >= ptr)) begin
            found_hi = 1'b1;
            id_hi    = ID_BITS'(i);
         end
      end
      return {|req, (found_hi ? id_hi : id_lo)};
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [ID_BITS-1:0]  r_wptr;
   logic [ID_BITS-1:0]  r_rptr;
   logic [ID_BITS-1:0]  r_issue_id;
   logic [RLATENCY-1:0] r_pipe_vld;
   logic [ID_BITS-1:0]  r_pipe_id [RLATENCY];

   logic [ID_BITS:0]    w_wpick;
   logic [ID_BITS:0]    w_rpick;
   logic                w_wany;
   logic                w_rany;
   logic [ID_BITS-1:0]  w_wid;
   logic [ID_BITS-1:0]  w_rid;
   logic                w_wacc;
   logic                w_racc;

   // Arbitration for both memory ports from the current valids and pointers.
   always_comb begin
      w_wpick = rr_pick(s_wvalid, r_wptr);
      w_rpick = rr_pick(s_rvalid, r_rptr);
   end

   assign w_wany = w_wpick[ID_BITS];
   assign w_wid  = w_wpick[ID_BITS-1:0];
   assign w_rany = w_rpick[ID_BITS];
   assign w_rid  = w_rpick[ID_BITS-1:0];

   // A grant is only meaningful on an enabled edge, so readies are cke-gated.
   // The granted port always has valid set, so valid&ready == grant here.
   assign w_wacc = cke & w_wany;
   assign w_racc = cke & w_rany;

   assign s_wready = w_wacc ? (NUM_PORTS'(1) << w_wid) : '0;
   assign s_rready = w_racc ? (NUM_PORTS'(1) << w_rid) : '0;

   // Round-robin pointers move one past the port accepted on this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wacc) begin
            r_wptr <= (w_wid == c_LAST_ID) ? '0 : w_wid + 1'b1;
         end
         if (w_racc) begin
            r_rptr <= (w_rid == c_LAST_ID) ? '0 : w_rid + 1'b1;
         end
      end
   end

   // Write issue: one cycle after acceptance; address/data hold when idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_wvalid <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
      end else if (cke) begin
         mem_wvalid <= w_wany;
         if (w_wany) begin
            mem_waddr <= w_waddr_arr[w_wid];
            mem_wdata <= w_wdata_arr[w_wid];
         end
      end
   end

   // Read issue: same timing as writes, and remembers which port it serves.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_rvalid <= 1'b0;
         mem_raddr  <= '0;
         r_issue_id <= '0;
      end else if (cke) begin
         mem_rvalid <= w_rany;
         if (w_rany) begin
            mem_raddr  <= w_raddr_arr[w_rid];
            r_issue_id <= w_rid;
         end
      end
   end

   // ID pipeline tracking the memory's read latency; stalls with the memory.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe_vld <= '0;
         for (int s = 0; s < RLATENCY; s++) begin
            r_pipe_id[s] <= '0;
         end
      end else if (cke) begin
         r_pipe_vld[0] <= mem_rvalid;
         r_pipe_id[0]  <= r_issue_id;
         for (int s = 1; s < RLATENCY; s++) begin
            r_pipe_vld[s] <= r_pipe_vld[s-1];
            r_pipe_id[s]  <= r_pipe_id[s-1];
         end
      end
   end

   // Read return: tail of the ID pipeline lines up with the memory output.
   assign m_rvalid = r_pipe_vld[RLATENCY-1] ? (NUM_PORTS'(1) << r_pipe_id[RLATENCY-1]) : '0;
   assign m_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_elixirchip_es1_spu_op_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_elixirchip_es1_spu_op_mem_arbiter
//  Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//             against a transaction-level reference model and a behavioural
//             memory attached to the mem_* ports.
//  Revision : 1.0  initial release
// ============================================================================
module tb_elixirchip_es1_spu_op_mem_arbiter;

   localparam int NP = 4;
   localparam int DB = 18;
   localparam int AB = 10;
   localparam int RL = 2;
   localparam int IB = 2;

   logic                clk     = 1'b0;
   logic                reset_n = 1'b1;
   logic                cke     = 1'b0;
   logic [NP*AB-1:0]    s_waddr;
   logic [NP*DB-1:0]    s_wdata;
   logic [NP-1:0]       s_wvalid = '0;
   logic [NP-1:0]       s_wready;
   logic [NP*AB-1:0]    s_raddr;
   logic [NP-1:0]       s_rvalid = '0;
   logic [NP-1:0]       s_rready;
   logic [DB-1:0]       m_rdata;
   logic [NP-1:0]       m_rvalid;
   logic [AB-1:0]       mem_waddr;
   logic [DB-1:0]       mem_wdata;
   logic                mem_wvalid;
   logic [AB-1:0]       mem_raddr;
   logic                mem_rvalid;
   logic [DB-1:0]       mem_rdata;

   // per-requester address/data, packed onto the flat buses
   logic [AB-1:0] wa [NP];
   logic [DB-1:0] wd [NP];
   logic [AB-1:0] ra [NP];

   always_comb begin
      s_waddr = '0;
      s_wdata = '0;
      s_raddr = '0;
      for (int i = 0; i < NP; i++) begin
         s_waddr[i*AB +: AB] = wa[i];
         s_wdata[i*DB +: DB] = wd[i];
         s_raddr[i*AB +: AB] = ra[i];
      end
   end

   always #5 clk = ~clk;

   elixirchip_es1_spu_op_mem_arbiter #(
      .NUM_PORTS (NP),
      .DATA_BITS (DB),
      .ADDR_BITS (AB),
      .RLATENCY  (RL)
   ) dut (
      .reset_n    (reset_n),
      .clk        (clk),
      .cke        (cke),
      .s_waddr    (s_waddr),
      .s_wdata    (s_wdata),
      .s_wvalid   (s_wvalid),
      .s_wready   (s_wready),
      .s_raddr    (s_raddr),
      .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),
      .m_rdata    (m_rdata),
      .m_rvalid   (m_rvalid),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wvalid (mem_wvalid),
      .mem_raddr  (mem_raddr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   // ------------------------------------------------------------------------
   // Behavioural memory: read-first, RL-cycle read latency, stalls on cke.
   // ------------------------------------------------------------------------
   logic [DB-1:0] phys  [1024];
   logic [DB-1:0] rpipe [RL];
   logic          mem_init = 1'b0;

   function automatic logic [DB-1:0] init_word(input int a);
      return DB'(a * 37 + 5);
   endfunction

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) phys[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (cke) begin
         rpipe[0] <= phys[mem_raddr];
         for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
         if (mem_wvalid) phys[mem_waddr] <= mem_wdata;
      end
   end
   assign mem_rdata = rpipe[RL-1];

   // ------------------------------------------------------------------------
   // Reference model (transaction level)
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   int            wptr, rptr;
   logic          ewv, erv;
   logic [AB-1:0] ewa, era;
   logic [DB-1:0] ewd;
   logic [DB-1:0] ref_mem [1024];

   typedef struct {
      int            port;
      logic [DB-1:0] data;
      int            age;   // enabled edges seen since acceptance
   } rd_t;
   rd_t inflight[$];

   int last_wg, last_rg;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // First requesting port searching ptr, ptr+1, ... with wrap; -1 if none.
   function automatic int rr_expect(input logic [NP-1:0] req, input int ptr);
      int idx;
      for (int k = 0; k < NP; k++) begin
         idx = (ptr + k) % NP;
         if (req[idx[IB-1:0]]) return idx;
      end
      return -1;
   endfunction

   // One clock cycle: check outputs against the model, then advance it.
   task automatic cyc();
      int            wg, rg;
      logic [NP-1:0] ew, er, emv;
      logic [DB-1:0] ed;
      #1;
      wg = rr_expect(s_wvalid, wptr);
      rg = rr_expect(s_rvalid, rptr);
      ew = '0;
      er = '0;
      if (cke && wg >= 0) ew[wg[IB-1:0]] = 1'b1;
      if (cke && rg >= 0) er[rg[IB-1:0]] = 1'b1;
      check_value("s_wready",   64'(s_wready),   64'(ew));
      check_value("s_rready",   64'(s_rready),   64'(er));
      check_value("mem_wvalid", 64'(mem_wvalid), 64'(ewv));
      check_value("mem_waddr",  64'(mem_waddr),  64'(ewa));
      check_value("mem_wdata",  64'(mem_wdata),  64'(ewd));
      check_value("mem_rvalid", 64'(mem_rvalid), 64'(erv));
      check_value("mem_raddr",  64'(mem_raddr),  64'(era));
      emv = '0;
      ed  = '0;
      foreach (inflight[j]) begin
         if (inflight[j].age == RL + 1) begin
            emv[inflight[j].port[IB-1:0]] = 1'b1;
            ed = inflight[j].data;
         end
      end
      check_value("m_rvalid", 64'(m_rvalid), 64'(emv));
      if (emv != '0) check_value("m_rdata", 64'(m_rdata), 64'(ed));
      last_wg = -1;
      last_rg = -1;
      @(posedge clk);
      if (cke) begin
         for (int j = inflight.size() - 1; j >= 0; j--) begin
            inflight[j].age++;
            if (inflight[j].age > RL + 1) inflight.delete(j);
         end
         // a write lands in memory one enabled edge after its acceptance
         if (ewv) ref_mem[ewa] = ewd;
         erv = (rg >= 0);
         if (rg >= 0) begin
            inflight.push_back('{rg, ref_mem[ra[rg[IB-1:0]]], 1});
            era     = ra[rg[IB-1:0]];
            rptr    = (rg + 1) % NP;
            last_rg = rg;
         end
         ewv = (wg >= 0);
         if (wg >= 0) begin
            ewa     = wa[wg[IB-1:0]];
            ewd     = wd[wg[IB-1:0]];
            wptr    = (wg + 1) % NP;
            last_wg = wg;
         end
      end
      #2;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check_value("rst_mem_wvalid", 64'(mem_wvalid), 64'd0);
      check_value("rst_mem_rvalid", 64'(mem_rvalid), 64'd0);
      check_value("rst_m_rvalid",   64'(m_rvalid),   64'd0);
      check_value("rst_mem_waddr",  64'(mem_waddr),  64'd0);
      check_value("rst_mem_wdata",  64'(mem_wdata),  64'd0);
      check_value("rst_mem_raddr",  64'(mem_raddr),  64'd0);
      wptr = 0;
      rptr = 0;
      ewv  = 1'b0;
      erv  = 1'b0;
      ewa  = '0;
      ewd  = '0;
      era  = '0;
      inflight.delete();
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   int first;
   int seen;

   initial begin
      for (int i = 0; i < NP; i++) begin
         wa[i] = '0;
         wd[i] = '0;
         ra[i] = '0;
      end
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      #2;
      do_reset();
      cke = 1'b1;

      // Single writer on port 2
      wa[2] = AB'(5);
      wd[2] = DB'(18'h1234);
      s_wvalid = 4'b0100;
      #1;
      check_value("t1_wready", 64'(s_wready), 64'h4);
      cyc();
      s_wvalid = '0;
      #1;
      check_value("t1_mem_wvalid", 64'(mem_wvalid), 64'd1);
      check_value("t1_mem_waddr",  64'(mem_waddr),  64'h5);
      check_value("t1_mem_wdata",  64'(mem_wdata),  64'h1234);
      cyc();

      // All ports reading: grants rotate 0,1,2,3,...
      for (int p = 0; p < NP; p++) ra[p] = AB'(p + 8);
      s_rvalid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         cyc();
         check_value("t2_grant", 64'(last_rg), 64'(k % NP));
      end
      s_rvalid = '0;
      for (int k = 0; k < 4; k++) cyc();

      // Write then read-back two cycles later
      wa[1] = AB'(3);
      wd[1] = DB'(18'h00AA);
      s_wvalid = 4'b0010;
      cyc();
      s_wvalid = '0;
      cyc();
      ra[0] = AB'(3);
      s_rvalid = 4'b0001;
      cyc();
      s_rvalid = '0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (m_rvalid == 4'b0001 && seen == 0) begin
            seen = 1;
            check_value("t3_rdata", 64'(m_rdata), 64'h00AA);
         end
         cyc();
      end
      check_value("t3_seen", 64'(seen), 64'd1);

      // Pointer at 3 with ports 0 and 3 requesting; wrap to 0 then 1
      ra[2] = AB'(20);
      s_rvalid = 4'b0100;
      cyc();
      ra[3] = AB'(21);
      s_rvalid = 4'b1001;
      cyc();
      check_value("t4_grant_a", 64'(last_rg), 64'd3);
      s_rvalid = 4'b0001;
      cyc();
      check_value("t4_grant_b", 64'(last_rg), 64'd0);
      ra[1] = AB'(22);
      s_rvalid = 4'b0011;
      cyc();
      check_value("t4_grant_c", 64'(last_rg), 64'd1);
      s_rvalid = '0;
      for (int k = 0; k < 4; k++) cyc();

      // Read then a 5-cycle cke stall
      ra[1] = AB'(9);
      s_rvalid = 4'b0010;
      cyc();
      first = 0;
      for (int n = 1; n <= 12; n++) begin
         cke      = (n <= 5) ? 1'b0 : 1'b1;
         s_rvalid = (n <= 5) ? 4'b0100 : 4'b0000;
         s_wvalid = (n <= 5) ? 4'b0100 : 4'b0000;
         #1;
         if (n <= 5) begin
            check_value("t5_rready", 64'(s_rready), 64'd0);
            check_value("t5_wready", 64'(s_wready), 64'd0);
         end
         if (m_rvalid[1] && first == 0) first = n;
         cyc();
      end
      check_value("t5_latency", 64'(first), 64'd8);

      // Reset with reads in flight
      ra[0] = AB'(1);
      ra[1] = AB'(2);
      s_rvalid = 4'b0011;
      cyc();
      cyc();
      s_rvalid = 4'b0110;
      do_reset();
      cyc();
      check_value("t6_first_grant", 64'(last_rg), 64'd1);
      s_rvalid = '0;
      for (int k = 0; k < RL; k++) begin
         #1;
         check_value("t6_no_rvalid", 64'(m_rvalid), 64'd0);
         cyc();
      end
      for (int k = 0; k < 4; k++) cyc();

      // Randomized traffic with random cke stalls
      for (int c = 0; c < 800; c++) begin
         cke = ($urandom_range(0, 9) != 0);
         cyc();
         if (last_wg >= 0) s_wvalid[last_wg[IB-1:0]] = 1'b0;
         if (last_rg >= 0) s_rvalid[last_rg[IB-1:0]] = 1'b0;
         for (int p = 0; p < NP; p++) begin
            if (!s_wvalid[p] && $urandom_range(0, 2) == 0) begin
               wa[p] = AB'($urandom_range(0, 15));
               wd[p] = DB'($urandom);
               s_wvalid[p] = 1'b1;
            end
            if (!s_rvalid[p] && $urandom_range(0, 2) == 0) begin
               ra[p] = AB'($urandom_range(0, 15));
               s_rvalid[p] = 1'b1;
            end
         end
      end
      cke = 1'b1;
      s_wvalid = '0;
      s_rvalid = '0;
      for (int k = 0; k < 6; k++) cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/elixirchip_es1_spu_op_mem_arbiter.md
Name: elixirchip_es1_spu_op_mem_arbiter

Overview:
- Round-robin arbiter that shares one elixirchip_es1_spu_op_mem instance among NUM_PORTS SPU requesters.
- The write and read ports of the memory are arbitrated independently, and a grant is issued for each every cycle.
- Each read response is routed back to the requester that issued it, using an ID pipeline matched to RLATENCY.
- Sits between the SPU operator lanes and the memory. The memory is driven with the same clk/cke.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16).
- DATA_BITS, 18, data width.
- ADDR_BITS, 10, address width.
- RLATENCY, 2, memory read latency in cycles (≥1). Must equal the memory's RLATENCY.
- ID_BITS, $clog2(NUM_PORTS), width of the requester index (derived; do not override).

Ports:
- reset_n  in  1  asynchronous active-low reset
- clk  in  1  clock
- cke  in  1  clock enable; all state holds when low
- s_waddr  in  NUM_PORTS*ADDR_BITS  per-port write address, port i at [i*ADDR_BITS +: ADDR_BITS]
- s_wdata  in  NUM_PORTS*DATA_BITS  per-port write data
- s_wvalid  in  NUM_PORTS  per-port write request
- s_wready  out  NUM_PORTS  per-port write grant
- s_raddr  in  NUM_PORTS*ADDR_BITS  per-port read address
- s_rvalid  in  NUM_PORTS  per-port read request
- s_rready  out  NUM_PORTS  per-port read grant
- m_rdata  out  DATA_BITS  read data, shared by all ports
- m_rvalid  out  NUM_PORTS  one-hot read-data strobe per port
- mem_waddr  out  ADDR_BITS  to memory s_waddr
- mem_wdata  out  DATA_BITS  to memory s_wdata
- mem_wvalid  out  1  to memory s_wvalid
- mem_raddr  out  ADDR_BITS  to memory s_raddr
- mem_rvalid  out  1  to memory s_rvalid
- mem_rdata  in  DATA_BITS  from memory m_rdata

Behaviour:
- Reset state (reset_n low, asynchronous): mem_wvalid=0, mem_rvalid=0, mem_waddr/mem_wdata/mem_raddr=0, m_rvalid=0, ID pipeline valids cleared, both round-robin pointers=0.
- Grant generation (combinational, one arbiter each for write and read):
  - Each arbiter has a pointer P. The granted port is the first i with valid[i]=1, searching P, P+1, …, NUM_PORTS-1, then 0, …, P-1.
  - s_wready/s_rready are one-hot (or zero) and are gated by cke. Each ready depends only on the valids and P, never on the port's own ready.
  - If no port is requesting, ready=0 and P is unchanged.
- Handshake and pointer update:
  - A request is accepted when valid&ready at a clk edge with cke=1.
  - On acceptance, P becomes (granted+1) mod NUM_PORTS.
  - A requester must hold its address/data stable until accepted.
- Issue (registered, 1 cycle):
  - A write accepted at edge t drives mem_waddr/mem_wdata with mem_wvalid=1 during cycle t+1. With no write accepted, mem_wvalid=0 and the address/data registers hold.
  - Reads follow the same rule on mem_raddr/mem_rvalid.
- Read return:
  - An ID shift register of depth RLATENCY (entry = valid bit + ID_BITS index) advances on cke.
  - It is loaded with {mem_rvalid, issued id}.
  - m_rvalid[id] = 1 when the tail entry is valid. m_rdata = mem_rdata, passed through combinationally.
  - Total latency from read acceptance to m_rvalid is 1+RLATENCY cycles. There is no backpressure on read data; the requester must accept it.
- Throughput: one write and one read per cycle, sustained.
- Simultaneous write and read to the same address in the same cycle: both are issued in the same cycle. The read-during-write result is whatever the memory defines; the arbiter does not reorder or forward.
- Ordering: the arbiter preserves per-port order, since requests are accepted in order and the latency is fixed.
- cke=0: all ready=0, all registers and the ID pipeline hold, mem_* outputs are frozen. The memory is stalled by the same cke, so data and ID stay aligned.
- Reset mid-operation: in-flight reads are discarded and no m_rvalid is produced for them. After release, arbitration restarts from port 0.
- Pointer wrap: a pointer at NUM_PORTS-1 advances to 0 after a grant to the last port.

Test Plan:
- NUM_PORTS=4, RLATENCY=2. Only port 2 writes addr 0x05 data 0x1234 → s_wready=0b0100 the same cycle; mem_wvalid=1, mem_waddr=0x05, mem_wdata=0x1234 one cycle later.
- All 4 ports hold s_rvalid=1 for 8 cycles after reset → grant sequence 0,1,2,3,0,1,2,3. Each port's m_rvalid fires 3 cycles after its grant, with m_rdata equal to the memory contents at its address.
- Write 0x00AA to addr 3 from port 1, then port 0 reads addr 3 two cycles later → m_rvalid=0b0001 with m_rdata=0x00AA.
- Ports 0 and 3 both request, pointer=3 → port 3 is granted first, then port 0. Pointer wraps to 0, then 1.
- Read accepted, then cke=0 for 5 cycles → no readies, no pointer change. m_rvalid is delayed by exactly 5 cycles with correct data.
- Reads in flight, reset_n pulsed low → m_rvalid=0 immediately and for the following RLATENCY+1 cycles. Pointers=0, and the first post-reset grant goes to the lowest requesting port.
